// File: rtl/dlx_rf_write_arbiter_if.sv
// dlx_rf_write_arbiter_if
//   Bundles the two writeback request channels and the registered register-file
//   write port of the DLX writeback arbiter.
//   Signals:
//     req0_valid/req0_rd/req0_data/req0_ready  ALU writeback channel (valid/ready)
//     req1_valid/req1_rd/req1_data/req1_ready  load-unit writeback channel (valid/ready)
//     RegWrite/rd/write_data                   registered RF write port
//     wr_count                                 count of committed (rd != 0) writes
//   Modports:
//     master  requester / RF side (drives requests, observes readies and RF port)
//     slave   arbiter side
interface dlx_rf_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              RegWrite;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  RegWrite, rd, write_data, wr_count
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output RegWrite, rd, write_data, wr_count
  );

endinterface

// File: rtl/dlx_rf_write_arbiter.sv
// dlx_rf_write_arbiter
//   Shares the single register-file write port between the ALU (port 0) and the
//   load unit (port 1). Grants are round-robin and combinational; the accepted
//   write is registered and shown on RegWrite/rd/write_data one cycle later.
//   Writes to r0 are acknowledged but never raise RegWrite. wr_count counts
//   committed (rd != 0) writes and wraps.
//   Ports:
//     clock    rising-edge clock
//     reset    synchronous, active-low reset
//     wb_hold  1 = issue no grants this cycle (registered write still completes)
//     bus      dlx_rf_write_arbiter_if.slave: request channels + RF write port
module dlx_rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wb_hold,
  dlx_rf_write_arbiter_if.slave        bus
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  port_e             last_grant_q, last_grant_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  // Grant logic. Reset and hold both suppress grants; on a tie the port that
  // did not win last time goes, so a continuously valid port waits at most
  // one cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && !wb_hold) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (last_grant_q == PORT1) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (bus.req0_valid) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // A grant is only ever given to a valid port, so any grant is a transfer.
  always_comb begin
    xfer     = grant0 || grant1;
    sel_rd   = grant1 ? bus.req1_rd   : bus.req0_rd;
    sel_data = grant1 ? bus.req1_data : bus.req0_data;
  end

  // Next-state for the registered write port, round-robin pointer and
  // commit counter. Without a transfer the index/data hold and RegWrite drops.
  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    wr_count_d   = wr_count_q;
    if (xfer) begin
      last_grant_d = grant1 ? PORT1 : PORT0;
      rd_d         = sel_rd;
      write_data_d = sel_data;
      // r0 writes are acknowledged but never committed
      reg_write_d  = (sel_rd != '0);
    end
    if (reg_write_d) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any registered write and re-arms port 0
  // to win the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant_q <= PORT1;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      wr_count_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Output drive
  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.RegWrite   = reg_write_q;
    bus.rd         = rd_q;
    bus.write_data = write_data_q;
    bus.wr_count   = wr_count_q;
  end

endmodule

// File: tb/tb_dlx_rf_write_arbiter.sv
// tb_dlx_rf_write_arbiter
//   Drives both writeback channels, predicts grants from the round-robin rule,
//   queues the expected RF writes and compares them as they appear on the
//   registered write port.
module tb_dlx_rf_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic wb_hold = 1'b0;

  dlx_rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  dlx_rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .wb_hold (wb_hold),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t sbq[$];
  wr_t mon_w;
  int  checks    = 0;
  int  errors    = 0;
  int  cyc       = 0;
  int  exp_count = 0;
  bit  last_port = 1'b1;
  bit  mon_en    = 1'b0;

  // Shared comparison helper
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the grant, queue the expected write
  task automatic applyStimulus(input bit rst_n, input bit hold,
                               input bit v0, input logic [4:0] rd0, input logic [31:0] d0,
                               input bit v1, input logic [4:0] rd1, input logic [31:0] d1,
                               output int granted);
    wr_t w;
    int  win;
    reset          = rst_n;
    wb_hold        = hold;
    bus.req0_valid = v0;
    bus.req0_rd    = rd0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_rd    = rd1;
    bus.req1_data  = d1;
    #2;
    win = -1;
    if (rst_n && !hold) begin
      if (v0 && v1)  win = (last_port == 1'b1) ? 0 : 1;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
    end
    checkOutput("req0_ready", {31'b0, bus.req0_ready}, {31'b0, win == 0});
    checkOutput("req1_ready", {31'b0, bus.req1_ready}, {31'b0, win == 1});
    if (win >= 0) begin
      w.due  = cyc + 1;
      w.rd   = (win == 0) ? rd0 : rd1;
      w.data = (win == 0) ? d0 : d1;
      w.we   = (w.rd != 5'd0);
      sbq.push_back(w);
      last_port = (win == 1);
    end
    if (!rst_n) last_port = 1'b1;
    granted = win;
    @(posedge clock);
    #1;
  endtask

  // Cycle count and reset effect on the model
  always @(posedge clock) begin
    cyc++;
    if (mon_en && !reset) begin
      exp_count = 0;
      sbq.delete();
    end
  end

  // Monitor: compare the RF write port with the scoreboard every cycle
  always @(negedge clock) begin
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        mon_w = sbq.pop_front();
        checkOutput("RegWrite", {31'b0, bus.RegWrite}, {31'b0, mon_w.we});
        if (mon_w.we) begin
          checkOutput("rd", {27'b0, bus.rd}, {27'b0, mon_w.rd});
          checkOutput("write_data", bus.write_data, mon_w.data);
          exp_count = (exp_count + 1) % 65536;
        end
      end else begin
        checkOutput("RegWrite idle", {31'b0, bus.RegWrite}, 32'd0);
      end
      checkOutput("wr_count", {16'b0, bus.wr_count}, exp_count[31:0]);
    end
  end

  int          g;
  bit          p0, p1;
  logic [4:0]  r0, r1;
  logic [31:0] x0, x1;

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_rd    = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_rd    = '0;
    bus.req1_data  = '0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    $display("[TB] reset with both ports valid");
    repeat (2) applyStimulus(0, 0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, g);
    checkOutput("reset RegWrite", {31'b0, bus.RegWrite}, 32'd0);
    checkOutput("reset wr_count", {16'b0, bus.wr_count}, 32'd0);
    applyStimulus(1, 0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, g);
    checkOutput("first grant after reset", g, 0);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 1, 5'd2, 32'h2, g);

    $display("[TB] contention");
    repeat (4) applyStimulus(1, 0, 1, 5'd3, 32'h11, 1, 5'd7, 32'h22, g);

    $display("[TB] single port and r0 discard");
    applyStimulus(1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, g);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF, g);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);

    $display("[TB] hold");
    applyStimulus(1, 0, 1, 5'd4, 32'hA4, 0, 5'd0, 32'h0, g);
    repeat (3) applyStimulus(1, 1, 1, 5'd6, 32'hA6, 1, 5'd8, 32'hA8, g);
    applyStimulus(1, 0, 1, 5'd6, 32'hA6, 1, 5'd8, 32'hA8, g);
    checkOutput("grant after hold", g, 1);
    applyStimulus(1, 0, 1, 5'd6, 32'hA6, 0, 5'd0, 32'h0, g);

    $display("[TB] randomized traffic");
    p0 = 0;
    p1 = 0;
    repeat (400) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1;
        r0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        x0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1;
        r1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        x1 = $urandom;
      end
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 4) == 0,
                    p0, r0, x0, p1, r1, x1, g);
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
    end

    $display("[TB] counter wrap");
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1, 0, 1, 5'((i % 31) + 1), $urandom, 0, 5'd0, 32'h0, g);
    end
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);
    checkOutput("wr_count preload", {16'b0, bus.wr_count}, 32'h0000FFFF);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 1, 5'd12, 32'hC0FFEE, g);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);
    checkOutput("wr_count wrap", {16'b0, bus.wr_count}, 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99, g);
    applyStimulus(1, 0, 1, 5'd10, 32'h1234, 0, 5'd0, 32'h0, g);
    applyStimulus(0, 0, 1, 5'd11, 32'h55, 1, 5'd13, 32'h66, g);
    checkOutput("mid-op reset RegWrite", {31'b0, bus.RegWrite}, 32'd0);
    checkOutput("mid-op reset wr_count", {16'b0, bus.wr_count}, 32'd0);
    applyStimulus(1, 0, 1, 5'd11, 32'h55, 1, 5'd13, 32'h66, g);
    checkOutput("grant after mid-op reset", g, 0);
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 1, 5'd13, 32'h66, g);

    repeat (3) applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, g);
    checkOutput("scoreboard drained", sbq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
